// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the manager-port state type.
package axi_pkg;

    localparam int AXI_ID_BITS = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        W    = 3'd4,
        B    = 3'd5
    } axi_mst_state_e;

    // EXOKAY is treated as an error: this port never issues exclusive accesses.
    function automatic logic resp_bad(input logic [1:0] resp);
        return (resp != RESP_OKAY);
    endfunction

endpackage

// File: rtl/axi_master_port.sv
// AXI4 manager port: turns single core requests into one in-order AR/R or AW/W/B burst.
module axi_master_port
    import axi_pkg::*;
#(
    parameter logic [AXI_ID_BITS-1:0] MASTER_ID = 4'd0,
    parameter int                     ADDR_W    = 32,
    parameter int                     DATA_W    = 32
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [3:0]             req_len,
    input  logic                   wdat_valid,
    output logic                   wdat_ready,
    input  logic [DATA_W-1:0]      wdat,
    input  logic [DATA_W/8-1:0]    wdat_strb,
    output logic                   rdat_valid,
    output logic [DATA_W-1:0]      rdat,
    output logic                   rdat_last,
    output logic                   done,
    output logic                   err,
    output logic [AXI_ID_BITS-1:0] ARID,
    output logic [ADDR_W-1:0]      ARADDR,
    output logic [3:0]             ARLEN,
    output logic [2:0]             ARSIZE,
    output logic [1:0]             ARBURST,
    output logic                   ARVALID,
    input  logic                   ARREADY,
    input  logic [AXI_ID_BITS-1:0] RID,
    input  logic [DATA_W-1:0]      RDATA,
    input  logic [1:0]             RRESP,
    input  logic                   RLAST,
    input  logic                   RVALID,
    output logic                   RREADY,
    output logic [AXI_ID_BITS-1:0] AWID,
    output logic [ADDR_W-1:0]      AWADDR,
    output logic [3:0]             AWLEN,
    output logic [2:0]             AWSIZE,
    output logic [1:0]             AWBURST,
    output logic                   AWVALID,
    input  logic                   AWREADY,
    output logic [DATA_W-1:0]      WDATA,
    output logic [DATA_W/8-1:0]    WSTRB,
    output logic                   WLAST,
    output logic                   WVALID,
    input  logic                   WREADY,
    input  logic [AXI_ID_BITS-1:0] BID,
    input  logic [1:0]             BRESP,
    input  logic                   BVALID,
    output logic                   BREADY
);

    axi_mst_state_e    r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_len;
    logic [3:0]        r_cnt;
    logic              r_err_acc;
    logic              r_done;
    logic              r_err;

    logic              w_wbeat;
    logic              w_last_cnt;
    logic              w_unused;

    assign w_wbeat    = (r_state == W) && wdat_valid && WREADY;
    assign w_last_cnt = (r_cnt == r_len);
    // Only one transaction is ever in flight, so returned IDs carry no information.
    assign w_unused   = ^{RID, BID, 1'b0};

    // Transaction FSM: latches the request, counts beats, accumulates errors.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= IDLE;
            r_addr    <= {ADDR_W{1'b0}};
            r_len     <= 4'd0;
            r_cnt     <= 4'd0;
            r_err_acc <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_addr    <= req_addr;
                        r_len     <= req_len;
                        r_cnt     <= 4'd0;
                        r_err_acc <= 1'b0;
                        r_state   <= req_write ? AW : AR;
                    end
                end
                AR: begin
                    if (ARREADY) r_state <= R;
                end
                R: begin
                    if (RVALID) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (RLAST) begin
                            r_done  <= 1'b1;
                            r_err   <= r_err_acc | resp_bad(RRESP) | !w_last_cnt;
                            r_state <= IDLE;
                        end else begin
                            // A non-final beat at the expected last position is an overrun.
                            r_err_acc <= r_err_acc | resp_bad(RRESP) | w_last_cnt;
                        end
                    end
                end
                AW: begin
                    if (AWREADY) r_state <= W;
                end
                W: begin
                    if (w_wbeat) begin
                        r_cnt <= r_cnt + 4'd1;
                        if (w_last_cnt) r_state <= B;
                    end
                end
                B: begin
                    if (BVALID) begin
                        r_done  <= 1'b1;
                        r_err   <= resp_bad(BRESP);
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign done       = r_done;
    assign err        = r_err;

    assign ARID       = MASTER_ID;
    assign ARADDR     = r_addr;
    assign ARLEN      = r_len;
    assign ARSIZE     = SIZE_4B;
    assign ARBURST    = BURST_INCR;
    assign ARVALID    = (r_state == AR);

    assign RREADY     = (r_state == R);
    assign rdat_valid = (r_state == R) && RVALID;
    assign rdat       = RDATA;
    assign rdat_last  = RLAST;

    assign AWID       = MASTER_ID;
    assign AWADDR     = r_addr;
    assign AWLEN      = r_len;
    assign AWSIZE     = SIZE_4B;
    assign AWBURST    = BURST_INCR;
    assign AWVALID    = (r_state == AW);

    assign WVALID     = (r_state == W) && wdat_valid;
    assign WDATA      = wdat;
    assign WSTRB      = wdat_strb;
    assign WLAST      = (r_state == W) && w_last_cnt;
    assign wdat_ready = (r_state == W) && WREADY;

    assign BREADY     = (r_state == B);

endmodule

// File: doc/axi_master_port.md
Name: axi_master_port

Overview:
AXI4 manager (initiator) port that converts a simple core-side request interface into AXI read bursts (AR/R) and write bursts (AW/W/B).
It is the counterpart of the SRAM/ROM subordinate wrappers and sits between a CPU fetch/LSU or a DMA engine and the AXI bus interconnect.
It keeps at most one outstanding transaction, issued in order.

Parameters:
- MASTER_ID, 4'd0: value driven on ARID/AWID (width `AXI_ID_BITS`).
- ADDR_W, 32: address width (`AXI_ADDR_BITS`).
- DATA_W, 32: data width (`AXI_DATA_BITS`); STRB width is DATA_W/8.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- req_valid  in  1  core request strobe
- req_ready  out  1  request accepted when req_valid & req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  start byte address
- req_len  in  4  beats - 1 (AXI LEN encoding)
- wdat_valid  in  1  core write beat available
- wdat_ready  out  1  write beat consumed
- wdat  in  DATA_W  write beat data
- wdat_strb  in  DATA_W/8  write beat byte strobes
- rdat_valid  out  1  read beat valid (core must accept; no backpressure)
- rdat  out  DATA_W  read beat data
- rdat_last  out  1  final read beat
- done  out  1  one-cycle pulse at transaction end
- err  out  1  valid with done; 1 = any non-OKAY response or a burst-length mismatch
- AR channel: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID (out); ARREADY (in)
- R channel: RID, RDATA, RRESP, RLAST, RVALID (in); RREADY (out)
- AW channel: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID (out); AWREADY (in)
- W channel: WDATA, WSTRB, WLAST, WVALID (out); WREADY (in)
- B channel: BID, BRESP, BVALID (in); BREADY (out)

Behaviour:
- Clock ACLK. Reset ARESETn is asynchronous, active-low.
- Reset state: state=IDLE; ARVALID, AWVALID, WVALID, RREADY, BREADY, rdat_valid, done, err all 0. Address, length and counter registers are 0.
- FSM states: IDLE, AR, R, AW, W, B.
- IDLE:
  - req_ready=1; all other handshake outputs 0.
  - On accept: latch addr, len and write flag; clear beat counter and err_acc.
  - Go to AW if req_write, else AR.
- AR:
  - ARVALID=1 from the cycle after accept.
  - ARADDR=latched addr, ARLEN=latched len, ARSIZE=3'b010, ARBURST=INCR (2'b01), ARID=MASTER_ID.
  - Payload stays stable until ARREADY; on ARVALID&ARREADY go to R.
  - ARVALID must never depend combinationally on ARREADY.
- R:
  - RREADY=1. rdat_valid=RVALID, rdat=RDATA, rdat_last=RLAST (combinational pass-through, zero latency).
  - Each beat: counter+1; err_acc |= (RRESP!=OKAY).
  - On the RLAST beat: err_acc |= (counter!=len); go to IDLE; done=1 and err=err_acc|current flags, pulsed the following cycle.
  - An RVALID beat when counter==len without RLAST: set err and keep waiting for RLAST. RID is ignored.
- AW:
  - AWVALID=1 with the same payload rules as AR.
  - On AWVALID&AWREADY go to W. W is not issued before the AW handshake.
- W:
  - WVALID=wdat_valid; WDATA=wdat; WSTRB=wdat_strb; WLAST=(counter==len); wdat_ready=WREADY.
  - Beat completes on WVALID&WREADY: counter+1.
  - On the beat with WLAST go to B.
  - wdat_valid low simply stalls the W channel; the port never inserts beats itself.
- B:
  - BREADY=1. On BVALID: err=(BRESP!=OKAY); done pulse; go to IDLE. BID is ignored.
- done/err are registered; they pulse for exactly one cycle, the cycle after the final handshake.
- A new request can be accepted in the cycle done is high (state is already IDLE).
- Counter is 4 bits; len=15 gives 16 beats. Counter never wraps within a legal burst.
- Reset asserted mid-burst: all VALID/READY outputs drop immediately (async). Return to IDLE with no done pulse; the partial transaction is discarded.
- Bursts crossing a 4 KB boundary are the caller's responsibility and are not checked.

Decomposition:
- Shared package axi_pkg:
  - BURST_FIXED, BURST_INCR, BURST_WRAP
  - RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR
  - SIZE_4B
  - typedef enum logic [2:0] axi_mst_state_e {IDLE, AR, R, AW, W, B}
- Single module with no sub-module; the beat counter and FSM are too small to split.

Test Plan:
- Single read, addr 0x0000_0010, len 0; ARREADY delayed 3 cycles → ARVALID held 4 cycles with ARADDR stable, ARLEN=0, ARBURST=01; one rdat beat with rdat_last=1; done=1, err=0 one cycle later.
- Read burst, len 3, RVALID gapped (1,0,1,1,0,1) → exactly 4 rdat pulses with data D0..D3, rdat_last only on D3; done once.
- Single write, addr 0x100, wstrb 4'b0011, data 0xDEADBEEF; AWREADY=1, WREADY after 2 cycles → WLAST=1, WSTRB=0011, BREADY=1; BRESP=OKAY gives done=1, err=0.
- Write burst, len 2, wdat_valid toggling and WREADY random → 3 W handshakes in order, WLAST only on the third; no WVALID before the AW handshake.
- Error paths:
  - BRESP=SLVERR → done with err=1.
  - Read len 3 with RLAST on beat 2 → done with err=1 after beat 2.
- Reset during beat 2 of a len-7 read → ARVALID/RREADY drop, no done; a subsequent read of len 0 completes normally.
